// File: rtl/mips_pkg.sv
// Shared defaults for the MIPS register file slice.
// Holds the default data width, register count and link offset, plus a helper
// that turns a register count into an address width.
package mips_pkg;

    localparam int unsigned DefaultDataW      = 32;
    localparam int unsigned DefaultNumRegs    = 32;
    localparam int unsigned DefaultLinkOffset = 2;

    // Address width needed to index num_regs registers (at least 1 bit).
    function automatic int unsigned addr_w(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/mips_regfile_bypass.sv
// One read port of the register file: selects between the stored value and
// same-cycle bypass sources, and reports whether the operand is ready.
// Ports:
//   read_reg    read address
//   stored_data value currently held in the addressed register
//   stored_busy pending bit of the addressed register
//   jal         link write in progress this cycle
//   link_data   value being written to the link register (pc + offset)
//   write_en    ordinary write in progress this cycle
//   write_reg   ordinary write address
//   write_data  ordinary write data
//   read_data   selected operand
//   read_valid  operand is not pending (or is being produced this cycle)
module mips_regfile_bypass
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W   = DefaultDataW,
    parameter int unsigned ADDR_W   = addr_w(DefaultNumRegs),
    parameter int unsigned LINK_REG = DefaultNumRegs - 1
) (
    input  logic [ADDR_W-1:0] read_reg,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              stored_busy,
    input  logic              jal,
    input  logic [DATA_W-1:0] link_data,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid
);

    localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);

    always_comb begin
        read_data  = stored_data;
        read_valid = ~stored_busy;
        if (read_reg == '0) begin
            // r0 is hardwired; never bypassed, never pending.
            read_data  = '0;
            read_valid = 1'b1;
        end else if (jal && (read_reg == LinkAddr)) begin
            // Link write has priority over an ordinary write to the same register.
            read_data  = link_data;
            read_valid = 1'b1;
        end else if (write_en && (write_reg == read_reg)) begin
            read_data  = write_data;
            read_valid = 1'b1;
        end
    end

endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS register file with a scoreboard of pending destinations.
// Two combinational read ports with write/link bypass, one write port, a jal
// link write, and a reserve port that marks a destination as pending.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   read_reg_1/2             read addresses
//   read_data_1/2            read data (combinational)
//   read_valid_1/2           operand not pending
//   write_reg/write_data     write address/data, signal_reg_write enables
//   jal, pc                  link write of pc + LINK_OFFSET to LINK_REG
//   reserve, reserve_reg     mark a destination pending
//   busy_vec                 registered pending bits
//   reserve_err              registered: last reserve hit an already-busy register
module mips_regfile_sb
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W      = DefaultDataW,
    parameter int unsigned NUM_REGS    = DefaultNumRegs,
    parameter int unsigned LINK_REG    = NUM_REGS - 1,
    parameter int unsigned LINK_OFFSET = DefaultLinkOffset,
    localparam int unsigned ADDR_W     = addr_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   read_reg_1,
    input  logic [ADDR_W-1:0]   read_reg_2,
    output logic [DATA_W-1:0]   read_data_1,
    output logic [DATA_W-1:0]   read_data_2,
    output logic                read_valid_1,
    output logic                read_valid_2,
    input  logic [ADDR_W-1:0]   write_reg,
    input  logic [DATA_W-1:0]   write_data,
    input  logic                signal_reg_write,
    input  logic                jal,
    input  logic [DATA_W-1:0]   pc,
    input  logic                reserve,
    input  logic [ADDR_W-1:0]   reserve_reg,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                reserve_err
);

    localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                reserve_err_q, reserve_err_d;

    logic [DATA_W-1:0] link_data;
    logic              wr_hit, jal_hit, res_hit, res_cleared;

    assign link_data = pc + DATA_W'(LINK_OFFSET);
    assign wr_hit    = signal_reg_write && (write_reg != '0);
    assign jal_hit   = jal && (LinkAddr != '0);
    assign res_hit   = reserve && (reserve_reg != '0);

    // A reserve is only an error if the register was busy and nothing
    // retires it on this same edge.
    assign res_cleared = (wr_hit && (write_reg == reserve_reg)) ||
                         (jal_hit && (LinkAddr == reserve_reg));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_hit) begin
            regs_d[write_reg] = write_data;
            busy_d[write_reg] = 1'b0;
        end
        // Applied after the ordinary write so the link value wins on a clash.
        if (jal_hit) begin
            regs_d[LinkAddr] = link_data;
            busy_d[LinkAddr] = 1'b0;
        end
        // Applied last: a new producer reserving the register keeps it pending.
        if (res_hit) begin
            busy_d[reserve_reg] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
        reserve_err_d = res_hit && busy_q[reserve_reg] && !res_cleared;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q        <= '{default: '0};
            busy_q        <= '0;
            reserve_err_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            busy_q        <= busy_d;
            reserve_err_q <= reserve_err_d;
        end
    end

    mips_regfile_bypass #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LINK_REG (LINK_REG)
    ) u_port_1 (
        .read_reg    (read_reg_1),
        .stored_data (regs_q[read_reg_1]),
        .stored_busy (busy_q[read_reg_1]),
        .jal         (jal_hit),
        .link_data   (link_data),
        .write_en    (wr_hit),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .read_data   (read_data_1),
        .read_valid  (read_valid_1)
    );

    mips_regfile_bypass #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LINK_REG (LINK_REG)
    ) u_port_2 (
        .read_reg    (read_reg_2),
        .stored_data (regs_q[read_reg_2]),
        .stored_busy (busy_q[read_reg_2]),
        .jal         (jal_hit),
        .link_data   (link_data),
        .write_en    (wr_hit),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .read_data   (read_data_2),
        .read_valid  (read_valid_2)
    );

    assign busy_vec    = busy_q;
    assign reserve_err = reserve_err_q;

endmodule
